// File: rtl/mips_avalon_master.sv
// Avalon-MM master adapter for the MIPS core load/store/fetch port; one request in flight.
// Latency: accept -> strobe next cycle -> response pulse one cycle after waitrequest drops.
// Backpressure: req_ready only in IDLE; strobes held stable through waitrequest, aborted on timeout.
module mips_avalon_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          CHECK_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_writedata,
    input  logic [3:0]  req_byteenable,
    output logic        resp_valid,
    output logic [31:0] resp_readdata,
    output logic        resp_error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] wait_cnt, wait_cnt_nxt;
    logic [31:0] addr_nxt, wdata_nxt, rdata_r, rdata_nxt;
    logic [3:0]  be_nxt;
    logic        rd_nxt, wr_nxt, err_r, err_nxt;

    assign req_ready     = (state == IDLE) && !reset;
    assign resp_valid    = (state == RESP);
    assign resp_readdata = rdata_r;
    assign resp_error    = err_r;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        addr_nxt     = avm_address;
        wdata_nxt    = avm_writedata;
        be_nxt       = avm_byteenable;
        rd_nxt       = avm_read;
        wr_nxt       = avm_write;
        rdata_nxt    = rdata_r;
        err_nxt      = err_r;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (CHECK_ALIGN && (req_address[1:0] != 2'b00)) begin
                        // Misaligned: answer with an error without touching the bus.
                        state_nxt = RESP;
                        err_nxt   = 1'b1;
                        rdata_nxt = 32'h0;
                    end else begin
                        state_nxt    = BUSY;
                        wait_cnt_nxt = 32'h0;
                        addr_nxt     = req_address;
                        wdata_nxt    = req_writedata;
                        be_nxt       = req_write ? req_byteenable : 4'hF;
                        rd_nxt       = !req_write;
                        wr_nxt       = req_write;
                    end
                end
            end
            BUSY: begin
                if (!avm_waitrequest) begin
                    state_nxt = RESP;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    rdata_nxt = avm_read ? avm_readdata : 32'h0;
                    err_nxt   = 1'b0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 32'd1;
                    if ((TIMEOUT_CYCLES != 0) && (wait_cnt_nxt == 32'(TIMEOUT_CYCLES))) begin
                        state_nxt = RESP;
                        rd_nxt    = 1'b0;
                        wr_nxt    = 1'b0;
                        rdata_nxt = 32'h0;
                        err_nxt   = 1'b1;
                    end
                end
            end
            RESP: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = 32'h0;
                rdata_nxt    = 32'h0;
                err_nxt      = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= 32'h0;
            avm_address    <= 32'h0;
            avm_writedata  <= 32'h0;
            avm_byteenable <= 4'h0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            rdata_r        <= 32'h0;
            err_r          <= 1'b0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_cnt_nxt;
            avm_address    <= addr_nxt;
            avm_writedata  <= wdata_nxt;
            avm_byteenable <= be_nxt;
            avm_read       <= rd_nxt;
            avm_write      <= wr_nxt;
            rdata_r        <= rdata_nxt;
            err_r          <= err_nxt;
        end
    end

endmodule
